// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory access controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/dmem_timer.sv
// Clearable up-counter; tc flags the last permitted BUSY cycle (count == TIMEOUT-1).
module dmem_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(TIMEOUT);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller: runs a req/ack transaction to data memory and stalls the CPU until done.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned n       = 16,
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic         stall,
  output logic         err_misalign,
  output logic         err_timeout,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-2:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  input  logic         mem_ack
);

  dmem_state_t  state_q, state_d;
  logic [n-1:0] readdata_q, readdata_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [n-2:0] mem_addr_q, mem_addr_d;
  logic [n-1:0] mem_wdata_q, mem_wdata_d;
  logic         err_misalign_q, err_misalign_d;
  logic         err_timeout_q, err_timeout_d;
  logic         tmr_clr, tmr_en, tmr_tc;
  logic         req;

  assign req = memread | memwrite;

  dmem_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (reset),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d        = state_q;
    readdata_d     = readdata_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    err_misalign_d = err_misalign_q;
    err_timeout_d  = err_timeout_q;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (req) begin
          // Write takes priority when both strobes are raised together.
          mem_we_d    = memwrite;
          mem_addr_d  = addr[n-1:1];
          mem_wdata_d = writedata;
          if (addr[0]) begin
            err_misalign_d = 1'b1;
            state_d        = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (!mem_we_q)
            readdata_d = mem_rdata;
          state_d = DONE;
        end else if (tmr_tc) begin
          err_timeout_d = 1'b1;
          if (!mem_we_q)
            readdata_d = '0;
          state_d = DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered request mirrors the next state so it is high for exactly the BUSY cycles.
    mem_req_d = (state_d == BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      readdata_q     <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      readdata_q     <= readdata_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      err_misalign_q <= err_misalign_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign stall        = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign readdata     = readdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed table-driven bench for dmem_ctrl plus hand-written reset corner cases.
module tb_dmem_ctrl;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          memread, memwrite;
  logic [N-1:0]  addr, writedata, readdata;
  logic          stall, err_misalign, err_timeout;
  logic          mem_req, mem_we;
  logic [N-2:0]  mem_addr;
  logic [N-1:0]  mem_wdata, mem_rdata;
  logic          mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_ctrl #(
    .n      (N),
    .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memread     (memread),
    .memwrite    (memwrite),
    .addr        (addr),
    .writedata   (writedata),
    .readdata    (readdata),
    .stall       (stall),
    .err_misalign(err_misalign),
    .err_timeout (err_timeout),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    int           ack_at;     // BUSY cycle (1-based) carrying the ack; 0 = never
    logic [N-1:0] rdata;
    int           exp_stall;
    int           exp_req;
    logic [N-1:0] exp_rd;
    logic         exp_mis;
    logic         exp_to;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls = 0;
    int reqs = 0;
    bit done = 1'b0;
    logic [N-2:0] exp_maddr;
    exp_maddr = v.addr[N-1:1];
    @(posedge clk); #1;
    memread = v.rd; memwrite = v.wr; addr = v.addr; writedata = v.wdata;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(exp_maddr));
          chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.wr));
          if (v.wr)
            chk($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
        end
        mem_ack   = (reqs == v.ack_at);
        mem_rdata = (reqs == v.ack_at) ? v.rdata : 16'h0BAD;
      end else begin
        mem_ack = 1'b0;
      end
      if (stall) stalls++;
      else done = 1'b1;
    end
    chk($sformatf("v%0d completed", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(v.exp_stall));
    chk($sformatf("v%0d req cycles", idx), 32'(reqs), 32'(v.exp_req));
    chk($sformatf("v%0d readdata", idx), 32'(readdata), 32'(v.exp_rd));
    chk($sformatf("v%0d err_misalign", idx), 32'(err_misalign), 32'(v.exp_mis));
    chk($sformatf("v%0d err_timeout", idx), 32'(err_timeout), 32'(v.exp_to));
    // Request is still held across the DONE->IDLE edge; it must not restart.
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d no restart req", idx), 32'(mem_req), 32'd0);
    chk($sformatf("v%0d idle stall", idx), 32'(stall), 32'd0);
  endtask

  initial begin
    //          rd    wr    addr      wdata     ack rdata     stl req rd        mis   to
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 3,  16'hBEEF, 4,  3,  16'hBEEF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 1,  16'h5555, 2,  1,  16'hBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0004, 16'h5A5A, 2,  16'h7777, 3,  2,  16'hBEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1,  16'h1357, 2,  1,  16'h1357, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1,  16'hAAAA, 1,  0,  16'h1357, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFE, 16'hFFFF, 2,  16'h0000, 3,  2,  16'h1357, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 16, 16'hCAFE, 17, 16, 16'hCAFE, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 0,  16'h0000, 17, 16, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1,  16'h4242, 2,  1,  16'h4242, 1'b0, 1'b0};

    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst readdata", 32'(readdata), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst err_misalign", 32'(err_misalign), 32'd0);
    chk("rst err_timeout", 32'(err_timeout), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset during the second BUSY cycle of a load, then a stray ack.
    @(posedge clk); #1;
    memread = 1'b1; addr = 16'h0030;
    @(negedge clk);
    chk("mid idle stall", 32'(stall), 32'd1);
    @(negedge clk);
    chk("mid busy1 req", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    chk("mid busy2 req", 32'(mem_req), 32'd1);
    reset = 1'b1; memread = 1'b0;
    #1;
    chk("mid rst req async", 32'(mem_req), 32'd0);
    chk("mid rst stall", 32'(stall), 32'd0);
    chk("mid rst err_misalign", 32'(err_misalign), 32'd0);
    chk("mid rst err_timeout", 32'(err_timeout), 32'd0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("late ack req", 32'(mem_req), 32'd0);
    chk("late ack stall", 32'(stall), 32'd0);
    chk("late ack readdata", 32'(readdata), 32'd0);

    run_vec(vecs[8], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
